bidir_bus_port: RTL and testbench
=================================

// Module: bidir_bus_port
// PURPOSE
//  Parametrised, registered bidirectional pad port with turnaround control; successor to the single-bit tristate styles.
//  Converts a valid/ready command stream (write = drive bus, read = sample bus) into pad drive/release timing.
//  Inserts guaranteed high-Z turnaround cycles on every direction change; synchronises sampled pad data.
//  Sits between a protocol engine (e.g. parallel flash/SRAM master) and the top-level inout pins.
// PARAMETERS
//  WIDTH        8  bits of the bidirectional bus
//  TURN_CYC     1  high-Z cycles inserted on any direction change (legal 1..15)
//  HOLD_CYC     1  cycles each write is held on the bus before next command may be accepted (legal 1..15)
//  SYNC_STAGES  2  flop stages on pad input before capture (legal 2..4)
// PORTS
//  clk        in     1      system clock, all logic on posedge
//  rst        in     1      asynchronous, active-high reset
//  cmd_valid  in     1      command present
//  cmd_ready  out    1      port accepts command this cycle
//  cmd_write  in     1      1 = write (drive cmd_data), 0 = read (sample bus)
//  cmd_data   in     WIDTH  write data
//  rsp_valid  out    1      one-cycle pulse, rsp_data valid (no backpressure)
//  rsp_data   out    WIDTH  sampled bus value for the read
//  bus_dir    out    1      1 = port currently owns/drives bus, 0 = released
//  pad_io     inout  WIDTH  bidirectional pins
// BEHAVIOUR
//  - Reset (async assert): state IDLE, output enable 0 (pad_io = Z immediately), drive reg 0, last_dir = READ,
//    cmd_ready 0 during reset then 1 first cycle after release, rsp_valid 0, rsp_data 0, bus_dir 0, sync flops 0.
//  - Accept = cmd_valid && cmd_ready; cmd_ready = (state == IDLE) only.
//  - States: IDLE, TURN, DRIVE, SAMPLE.
//  - IDLE, accept, dir unchanged: write -> DRIVE; read -> SAMPLE.
//  - IDLE, accept, dir changed: -> TURN; the pending command is latched; TURN counts TURN_CYC cycles with OE = 0, then DRIVE/SAMPLE.
//  - DRIVE: drive reg loaded with cmd_data at accept edge; OE = 1; held HOLD_CYC cycles, then IDLE.
//  - After a write, IDLE keeps OE = 1 with last data (bus parked driven) so back-to-back writes have no Z gaps.
//  - Write, same dir, accepted at edge T: pad shows new data from T; cmd_ready high again after HOLD_CYC cycles.
//  - SAMPLE: OE = 0; waits SYNC_STAGES cycles; then captures the sync chain output into rsp_data, pulses rsp_valid, goes to IDLE.
//  - Read latency, same dir: rsp_valid exactly SYNC_STAGES+1 cycles after accept edge.
//  - Read latency, dir changed: the same plus TURN_CYC.
//  - OE never high in TURN/SAMPLE; OE never transitions 1->0->1 without TURN_CYC Z cycles between drive and re-drive after a read.
//  - bus_dir = registered OE.
//  - rsp_data holds its value until the next read completes.
//  - cmd_valid while not ready: ignored, no side effects; the command must be held by the master.
//  - Reset mid-DRIVE/TURN/SAMPLE: command dropped, no rsp_valid, bus Z the same instant.
//  - Counters: 4-bit, saturating-free, reload on state entry.
// STRUCTURE
//  - Shared package/header bidir_pkg: state encoding constants (IDLE = 0, TURN = 1, DRIVE = 2, SAMPLE = 3), DIR_READ = 0, DIR_WRITE = 1.
//  - Sub-module bidir_pad_cell: per-bus tristate drive (assign pad = oe ? o : Z) plus SYNC_STAGES input synchroniser, WIDTH wide.
//    Instantiated once; vendor-primitive IOBUF swap stays local to it.
//  - Top holds the FSM, counters, command latch, response register.
// TESTING
//  - Reset: assert rst mid-DRIVE of 0xA5 -> pad_io = Z same cycle, rsp_valid 0, bus_dir 0, cmd_ready 1 one cycle after release.
//  - Two writes 0x11, 0x22 (defaults): pad 0x11 one cycle, then 0x22, no Z between, cmd_ready low 1 cycle per write.
//  - Read after write, external drives 0x3C: pad Z for 1 TURN cycle, rsp_valid at accept+4, rsp_data = 0x3C.
//  - Write after read, TURN_CYC = 3: exactly 3 Z cycles before 0x5A appears; bus_dir rises with OE.
//  - cmd_valid held during TURN/DRIVE: no second accept until IDLE; data 0x77 not altered by changed cmd_data mid-hold.
//  - Scoreboard random 1000 commands: check no cycle with OE = 1 while the bench model drives; read data matches model.

Source files
------------

// File: rtl/bidir_pkg.sv
// rtl/bidir_pkg.sv - shared state encoding, direction constants and counter helper for the bidirectional bus port
package bidir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_SAMPLE = 2'd3
    } state_e;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int CNT_W = 4;

    // Counter reload value for a cycle count parameter, truncated to the counter width.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/bidir_pad_cell.sv
// rtl/bidir_pad_cell.sv - tristate pad driver plus multi-stage input synchroniser, WIDTH wide
module bidir_pad_cell #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe_i,
    input  logic [WIDTH-1:0] o_i,
    output logic [WIDTH-1:0] sync_o,
    inout  wire  [WIDTH-1:0] pad_io
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Pad driver; a vendor IOBUF instance would replace this line only.
    assign pad_io = oe_i ? o_i : {WIDTH{1'bz}};

    // Input synchroniser: the pad value ripples through SYNC_STAGES flops before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_io;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_bus_port.sv
// rtl/bidir_bus_port.sv - command-driven bidirectional bus port with turnaround, hold and synchronised sampling
module bidir_bus_port #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYC    = 1,
    parameter int HOLD_CYC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             bus_dir,
    inout  wire  [WIDTH-1:0] pad_io
);

    import bidir_pkg::*;

    localparam logic [CNT_W-1:0] TURN_LD = cnt_load(TURN_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD = cnt_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] SYNC_LD = cnt_load(SYNC_STAGES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_write_q, pend_write_d;
    logic             last_dir_q, last_dir_d;
    logic [WIDTH-1:0] drive_q, drive_d;
    logic             oe_q, oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             init_q;
    logic             accept;
    logic [WIDTH-1:0] sync_data;

    // Ready only in IDLE, and held low until the first clock after reset release.
    assign cmd_ready = init_q && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign bus_dir   = oe_q;

    bidir_pad_cell #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pad (
        .clk    (clk),
        .rst    (rst),
        .oe_i   (oe_q),
        .o_i    (drive_q),
        .sync_o (sync_data),
        .pad_io (pad_io)
    );

    // Next-state logic: turnaround on direction change, write hold, sample wait then capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_write_d = pend_write_q;
        last_dir_d   = last_dir_q;
        drive_d      = drive_q;
        oe_d         = oe_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_dir_d   = cmd_write;
                    pend_write_d = cmd_write;
                    if (cmd_write == DIR_WRITE) begin
                        drive_d = cmd_data;
                    end
                    if (cmd_write != last_dir_q) begin
                        // Direction flip: release the bus first, run the turnaround.
                        state_d = ST_TURN;
                        cnt_d   = TURN_LD;
                        oe_d    = 1'b0;
                    end else if (cmd_write == DIR_WRITE) begin
                        state_d = ST_DRIVE;
                        cnt_d   = HOLD_LD;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = ST_SAMPLE;
                        cnt_d   = SYNC_LD;
                        oe_d    = 1'b0;
                    end
                end
            end
            ST_TURN: begin
                oe_d = 1'b0;
                if (cnt_q == 4'd1) begin
                    if (pend_write_q == DIR_WRITE) begin
                        state_d = ST_DRIVE;
                        cnt_d   = HOLD_LD;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = ST_SAMPLE;
                        cnt_d   = SYNC_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DRIVE: begin
                // Bus stays parked driven on return to IDLE.
                oe_d = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                oe_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = sync_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_write_q <= DIR_READ;
            last_dir_q   <= DIR_READ;
            drive_q      <= '0;
            oe_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            init_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_write_q <= pend_write_d;
            last_dir_q   <= last_dir_d;
            drive_q      <= drive_d;
            oe_q         <= oe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            init_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bidir_bus_port.sv
// tb/tb_bidir_bus_port.sv - randomized self-checking bench for bidir_bus_port
module tb_bidir_bus_port;

    localparam int WIDTH = 8;
    localparam int TURN  = 3;
    localparam int HOLD  = 1;
    localparam int SYNC  = 2;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             bus_dir;
    wire  [WIDTH-1:0] pad_io;

    logic             tb_oe;
    logic [WIDTH-1:0] tb_data;

    int n_checks;
    int n_errors;

    // Reference state: last committed direction, last written value, last read value.
    logic             m_dir;
    logic [WIDTH-1:0] m_park;
    logic [WIDTH-1:0] m_rsp;

    assign pad_io = tb_oe ? tb_data : {WIDTH{1'bz}};

    bidir_bus_port #(
        .WIDTH       (WIDTH),
        .TURN_CYC    (TURN),
        .HOLD_CYC    (HOLD),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .bus_dir   (bus_dir),
        .pad_io    (pad_io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", cmd_ready, 1);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_bus_dir", bus_dir, m_dir);
            if (m_dir) chk("idle_park", pad_io, m_park);
            chk("idle_rsp_data", rsp_data, m_rsp);
        end
    endtask

    // Issue one command at a negedge and follow it cycle by cycle until ready returns.
    task automatic do_cmd(input logic wr, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ext);
        int turn;
        int kend;
        int guard;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_data  = d;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", cmd_ready, 1);
        turn  = (wr != m_dir) ? TURN : 0;
        kend  = wr ? (turn + HOLD) : (turn + SYNC + 1);
        m_dir = wr;
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            chk("ready", cmd_ready, k == kend);
            chk("rsp_valid", rsp_valid, (!wr) && (k == kend));
            chk("bus_dir", bus_dir, wr && (k >= turn));
            chk("no_contention", bus_dir && tb_oe, 0);
            if (wr && k >= turn) chk("pad_data", pad_io, d);
            if (!wr && k == kend) m_rsp = ext;
            chk("rsp_data", rsp_data, m_rsp);
            if (!wr && k == 0) begin
                tb_oe   = 1'b1;
                tb_data = ext;
            end
            if (k == kend) begin
                cmd_valid = 1'b0;
                if (!wr) tb_oe = 1'b0;
            end else begin
                cmd_data  = WIDTH'($urandom);
                cmd_write = 1'($urandom);
            end
        end
        if (wr) m_park = d;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_data  = '0;
        tb_oe     = 1'b0;
        tb_data   = '0;
        m_dir     = 1'b0;
        m_park    = '0;
        m_rsp     = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_bus_dir", bus_dir, 0);
        rst = 1'b0;
        chk("rel_ready_low", cmd_ready, 0);
        @(negedge clk);
        chk("rel_ready_high", cmd_ready, 1);

        // Reset in the middle of driving 0xA5.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_data  = 8'hA5;
        begin
            int guard;
            guard = 0;
            while (!bus_dir && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("a5_driven", bus_dir, 1);
        chk("a5_pad", pad_io, 8'hA5);
        #2 rst = 1'b1;
        #1;
        chk("midrst_bus_dir", bus_dir, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rel_ready_low", cmd_ready, 0);
        @(negedge clk);
        chk("midrst_rel_ready_high", cmd_ready, 1);
        chk("midrst_rel_rsp_valid", rsp_valid, 0);
        m_dir  = 1'b0;
        m_park = '0;
        m_rsp  = '0;

        // Directed sequence: back-to-back writes, read after write, write after read, held data.
        do_cmd(1'b1, 8'h11, 8'h00);
        do_cmd(1'b1, 8'h22, 8'h00);
        do_cmd(1'b0, 8'h00, 8'h3C);
        chk("read_3c", rsp_data, 8'h3C);
        idle_cycles(1);
        do_cmd(1'b1, 8'h5A, 8'h00);
        do_cmd(1'b1, 8'h77, 8'h00);
        idle_cycles(2);
        do_cmd(1'b0, 8'h00, 8'hC3);
        do_cmd(1'b0, 8'h00, 8'h96);
        chk("read_96", rsp_data, 8'h96);

        // Random command stream.
        for (int n = 0; n < 1000; n++) begin
            do_cmd(1'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
